// File: rtl/fast2slow_hold.sv
// rtl/fast2slow_hold.sv - FIFO that presents one buffered word per slow-consumer tick window
// Words are held stable on outdata between ticks; an empty tick drops out_valid but keeps the old word.
module fast2slow_hold #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                    fast_clk,
   input  logic                    rst,
   input  logic                    slow_tick,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   outdata,
   output logic                    out_valid,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   assign in_ready = (count != FULL);
   assign push     = in_valid && in_ready;
   // pop is decided on the pre-edge count, so a push into an empty buffer is never bypassed
   assign pop      = slow_tick && (count != '0);
   assign level    = count;

   always_ff @(posedge fast_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         outdata   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (slow_tick) begin
            out_valid <= pop;
            if (pop) begin
               outdata <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + PTR_W'(1);
            end
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fast2slow_hold.sv
// tb/tb_fast2slow_hold.sv - scoreboard bench for fast2slow_hold with a queue-based reference model
module tb_fast2slow_hold;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          slow_tick = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] outdata;
   logic          out_valid;
   logic [$clog2(DEPTH):0] level;

   fast2slow_hold #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .fast_clk  (clk),
      .rst       (rst),
      .slow_tick (slow_tick),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .outdata   (outdata),
      .out_valid (out_valid),
      .level     (level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic          mon_en = 1'b0;

   // reference model: buffered words, the word the consumer sees, and one expected entry per tick
   logic [DW-1:0] mq [$];
   logic [DW:0]   sbq [$];
   logic [DW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          tick_seen = 1'b0;
   logic [DW:0]   sb_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic can_push;
      can_push = (mq.size() != DEPTH) && in_valid;
      if (slow_tick) begin
         if (mq.size() > 0) begin
            m_data  = mq.pop_front();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         sbq.push_back({m_valid, m_data});
      end
      if (can_push) mq.push_back(in_data);
      tick_seen = slow_tick;
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input logic t);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      slow_tick = t;
      @(posedge clk);
      model_edge();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst       = 1'b1;
      in_valid  = 1'b0;
      slow_tick = 1'b0;
      mq.delete();
      sbq.delete();
      m_data    = '0;
      m_valid   = 1'b0;
      tick_seen = 1'b0;
      #1;
      chk("rst_outdata", outdata, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (tick_seen) begin
            tick_seen = 1'b0;
            if (sbq.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               sb_e = sbq.pop_front();
               chk("sb_valid", out_valid, sb_e[DW]);
               chk("sb_data", outdata, sb_e[DW-1:0]);
            end
         end
         chk("level", level, mq.size());
         chk("in_ready", in_ready, mq.size() != DEPTH);
         chk("hold_valid", out_valid, m_valid);
         chk("hold_data", outdata, m_data);
      end
   end

   int tick_per;
   int val_per;

   initial begin
      // three words, consumed one per 8-cycle window, then an empty window
      do_reset();
      step(1, 8'h11, 0);
      step(1, 8'h22, 0);
      step(1, 8'h33, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1);
         #1;
         if (k < 3) begin
            chk("seq_valid", out_valid, 1);
            chk("seq_data", outdata, 32'h11 * (k + 1));
         end else begin
            chk("seq_end_valid", out_valid, 0);
            chk("seq_end_data", outdata, 32'h33);
         end
         repeat (7) step(0, 0, 0);
      end

      // fill to DEPTH, a fifth word is refused, then one tick frees a slot
      do_reset();
      for (int k = 0; k < DEPTH; k++) step(1, 8'hA0 + 8'(k), 0);
      step(1, 8'hAF, 0);
      #1;
      chk("full_level", level, DEPTH);
      chk("full_ready", in_ready, 0);
      step(1, 8'hAE, 1);
      #1;
      chk("full_pop_data", outdata, 32'hA0);
      chk("full_pop_level", level, DEPTH - 1);
      chk("full_pop_ready", in_ready, 1);
      repeat (DEPTH) step(0, 0, 1);
      #1;
      chk("full_last", outdata, 32'hA3);

      // push into empty buffer on a tick: no bypass
      do_reset();
      step(1, 8'hA5, 1);
      #1;
      chk("nobypass_valid", out_valid, 0);
      step(0, 0, 1);
      #1;
      chk("nobypass_data", outdata, 32'hA5);
      chk("nobypass_valid2", out_valid, 1);

      // simultaneous push and pop at count 2
      do_reset();
      step(1, 8'hB1, 0);
      step(1, 8'hB2, 0);
      step(1, 8'hB3, 1);
      #1;
      chk("pushpop_level", level, 2);
      chk("pushpop_data", outdata, 32'hB1);
      step(0, 0, 1);
      step(0, 0, 1);
      #1;
      chk("pushpop_order", outdata, 32'hB3);

      // asynchronous reset mid-operation discards buffered words
      do_reset();
      step(1, 8'h01, 0);
      step(1, 8'h02, 0);
      step(1, 8'h03, 1);
      #1;
      chk("pre_rst_valid", out_valid, 1);
      do_reset();
      step(0, 0, 1);
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_level", level, 0);

      // randomized traffic with varying tick and push density
      for (int blk = 0; blk < 20; blk++) begin
         case (blk % 4)
            0: tick_per = 8;
            1: tick_per = 2;
            2: tick_per = 1;
            default: tick_per = 4;
         endcase
         val_per = 1 + (blk % 3);
         for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, val_per - 1) == 0, 8'($urandom),
                 $urandom_range(0, tick_per - 1) == 0);
         end
      end
      step(0, 0, 0);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("sb_drained", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fast2slow_hold.md
FAST2SLOW_HOLD -- requirements
Module: fast2slow_hold

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of each data word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the buffer depth in words; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port fast_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port slow_tick, input, 1 bit: single-cycle strobe, synchronous to fast_clk, marking each slow-consumer sample window.
REQ-006 SHALL have port in_data, input, DATA_WIDTH bits: producer word.
REQ-007 SHALL have port in_valid, input, 1 bit: producer word present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-009 SHALL have port outdata, output, DATA_WIDTH bits: word held stable for the slow consumer.
REQ-010 SHALL have port out_valid, output, 1 bit: outdata carries a new word for the current slow window.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: the number of words currently buffered.

Function
REQ-012 SHALL implement a DEPTH-entry FIFO with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, and a count of 0..DEPTH.
REQ-013 SHALL drive in_ready = (count != DEPTH) combinationally from registered count.
REQ-014 SHALL push in_data at a rising edge when in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-015 On a cycle with slow_tick=1 and count>0, the next edge SHALL load the head word into outdata, set out_valid=1, and pop.
REQ-016 On a cycle with slow_tick=1 and count=0, the next edge SHALL clear out_valid to 0 and leave outdata holding its previous value.
REQ-017 With slow_tick=0, outdata and out_valid SHALL hold unchanged, so outdata changes only on the edge after a slow_tick.
REQ-018 On a simultaneous push and tick-pop, both SHALL occur and count SHALL be unchanged.
REQ-019 A push and tick in the same cycle with count=0 SHALL NOT bypass: out_valid->0, and the word is presented at the following tick.
REQ-020 When count=DEPTH and slow_tick=1, the pop SHALL free a slot, in_ready SHALL rise one cycle later, and no push SHALL occur in the tick cycle.
REQ-021 Latency: a word pushed at edge t SHALL appear on outdata at the edge following the first slow_tick asserted strictly after edge t.
REQ-022 Words SHALL emerge in push order with none lost or duplicated.
REQ-023 level SHALL equal count, registered.
REQ-024 Back-to-back slow_tick on consecutive cycles SHALL be legal, popping one word per tick.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force pointers=0, count=0, level=0, outdata=0, out_valid=0; in_ready then reads 1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words, with no word presented after rst is released until a new push.
REQ-027 The first edge after rst falls SHALL be a normal operating edge.

Verification
REQ-028 Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then tick every 8 cycles -> outdata 0x11, 0x22, 0x33 each held 8 cycles with out_valid=1, then out_valid=0 with outdata=0x33.
REQ-029 Push 4 words with no tick -> level=4, in_ready=0; fifth in_valid is ignored; tick -> first word out, level=3, in_ready=1 next cycle.
REQ-030 count=0, push 0xA5 in the same cycle as a tick -> out_valid=0 after that edge; next tick -> outdata=0xA5, out_valid=1.
REQ-031 count=2, push and tick in the same cycle -> level stays 2, order preserved.
REQ-032 Push 0x01..0x03, assert rst asynchronously between edges -> outputs are 0 immediately; after release, tick -> out_valid=0.
REQ-033 Random in_valid and slow_tick over 10k cycles with DEPTH=4 -> scoreboard shows in-order delivery with no loss and no duplication.
